// File: rtl/usb_pkg.sv
// Shared USB transmit-path types: NRZI encoder states and {dp,dm} bus levels.
package usb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      EOP_SE0,
      EOP_J
   } nrzi_state_t;

   localparam logic [1:0] BUS_J   = 2'b10;
   localparam logic [1:0] BUS_K   = 2'b01;
   localparam logic [1:0] BUS_SE0 = 2'b00;

   function automatic logic [1:0] bus_of(input logic level);
      return level ? BUS_J : BUS_K;
   endfunction

endpackage

// File: rtl/nrzi_encoder.sv
// NRZI line encoder with end-of-packet (SE0 then J) generation.
// One bit per bit clock; all outputs registered.
module nrzi_encoder
   import usb_pkg::*;
#(
   parameter int EOP_SE0_BITS = 2,
   parameter int EOP_J_BITS   = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic bs_sending,
   input  logic in_bit,
   output logic dp,
   output logic dm,
   output logic nrzi_sending,
   output logic eop_done,
   output logic overrun
);

   if (EOP_SE0_BITS < 1 || EOP_SE0_BITS > 15) begin : g_bad_se0
      $error("EOP_SE0_BITS out of range 1..15");
   end
   if (EOP_J_BITS < 1 || EOP_J_BITS > 15) begin : g_bad_j
      $error("EOP_J_BITS out of range 1..15");
   end

   localparam logic [3:0] SE0_LAST = 4'(EOP_SE0_BITS);
   localparam logic [3:0] J_LAST   = 4'(EOP_J_BITS);

   nrzi_state_t state;
   logic        level;
   logic [3:0]  count;
   logic        base;
   logic        nxt_level;
   logic        se0_end;
   logic        j_end;

   // A new packet always encodes against J, whatever level was left behind.
   assign base      = (state == IDLE) ? 1'b1 : level;
   assign nxt_level = in_bit ? base : ~base;
   assign se0_end   = (count == SE0_LAST);
   assign j_end     = (count == J_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= 4'd0;
      end else begin
         unique case (state)
            IDLE:    count <= 4'd0;
            SEND:    if (!bs_sending) count <= 4'd1;
            EOP_SE0: count <= se0_end ? 4'd1 : count + 4'd1;
            EOP_J:   count <= j_end ? 4'd0 : count + 4'd1;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         level        <= 1'b1;
         {dp, dm}     <= BUS_J;
         nrzi_sending <= 1'b0;
         eop_done     <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         eop_done <= 1'b0;
         overrun  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bs_sending) begin
                  level        <= nxt_level;
                  {dp, dm}     <= bus_of(nxt_level);
                  nrzi_sending <= 1'b1;
                  state        <= SEND;
               end else begin
                  {dp, dm} <= BUS_J;
               end
            end
            SEND: begin
               if (bs_sending) begin
                  level    <= nxt_level;
                  {dp, dm} <= bus_of(nxt_level);
               end else begin
                  {dp, dm} <= BUS_SE0;
                  state    <= EOP_SE0;
               end
            end
            EOP_SE0: begin
               overrun <= bs_sending;
               if (se0_end) begin
                  {dp, dm} <= BUS_J;
                  eop_done <= (J_LAST == 4'd1);
                  state    <= EOP_J;
               end
            end
            EOP_J: begin
               overrun <= bs_sending;
               if (j_end) begin
                  level        <= 1'b1;
                  {dp, dm}     <= BUS_J;
                  nrzi_sending <= 1'b0;
                  state        <= IDLE;
               end else begin
                  // Pulse lines up with the final J bit-time on the wire.
                  eop_done <= (count + 4'd1 == J_LAST);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nrzi_encoder.sv
// Randomized and directed bench for nrzi_encoder, two parameter sets
// checked against a packet-level reference model.
module tb_nrzi_encoder;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic bs_sending = 1'b0;
   logic in_bit = 1'b0;

   logic dp0, dm0, ns0, ed0, ov0;
   logic dp1, dm1, ns1, ed1, ov1;

   int n_run = 0;
   int n_fail = 0;

   int se0_n[2] = '{2, 3};
   int j_n[2]   = '{1, 2};
   logic lvl[2];
   logic busy[2];
   int   pos[2];
   logic [4:0] exp_o[2];

   always #5 clock = ~clock;

   nrzi_encoder u0 (
      .clock(clock), .reset(reset),
      .bs_sending(bs_sending), .in_bit(in_bit),
      .dp(dp0), .dm(dm0), .nrzi_sending(ns0),
      .eop_done(ed0), .overrun(ov0)
   );

   nrzi_encoder #(.EOP_SE0_BITS(3), .EOP_J_BITS(2)) u1 (
      .clock(clock), .reset(reset),
      .bs_sending(bs_sending), .in_bit(in_bit),
      .dp(dp1), .dm(dm1), .nrzi_sending(ns1),
      .eop_done(ed1), .overrun(ov1)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_run++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %b want %b", tag, got, want);
      end
   endtask

   // Reference: pos is the bit-time index inside the EOP (-1 outside it).
   task automatic model(input int k, input logic r, input logic bs, input logic b);
      int total;
      total = se0_n[k] + j_n[k];
      if (r) begin
         lvl[k] = 1'b1; busy[k] = 1'b0; pos[k] = -1;
         exp_o[k] = 5'b10000;
      end else if (pos[k] >= 0) begin
         pos[k]++;
         if (pos[k] == total) begin
            pos[k] = -1; busy[k] = 1'b0; lvl[k] = 1'b1;
            exp_o[k] = {4'b1000, bs};
         end else if (pos[k] < se0_n[k]) begin
            exp_o[k] = {4'b0010, bs};
         end else begin
            exp_o[k] = {3'b101, pos[k] == total - 1, bs};
         end
      end else if (busy[k]) begin
         if (bs) begin
            if (!b) lvl[k] = !lvl[k];
            exp_o[k] = {lvl[k], !lvl[k], 3'b100};
         end else begin
            pos[k] = 0;
            exp_o[k] = 5'b00100;
         end
      end else begin
         if (bs) begin
            lvl[k] = b;
            busy[k] = 1'b1;
            exp_o[k] = {lvl[k], !lvl[k], 3'b100};
         end else begin
            exp_o[k] = 5'b10000;
         end
      end
   endtask

   task automatic step(input logic r, input logic bs, input logic b);
      reset = r; bs_sending = bs; in_bit = b;
      @(posedge clock);
      model(0, r, bs, b);
      model(1, r, bs, b);
      #1;
      chk("u0_outs", 16'({dp0, dm0, ns0, ed0, ov0}), 16'(exp_o[0]));
      chk("u1_outs", 16'({dp1, dm1, ns1, ed1, ov1}), 16'(exp_o[1]));
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [7:0]  dpv;
      logic [8:0]  eopv;
      logic [5:0]  holdv;
      logic [11:0] linev;
      logic [5:0]  donev;
      logic        ns_all;
      int          ovcnt;
      logic        bs_r;
      logic [7:0]  sync_bits;

      repeat (3) step(1'b1, 1'b0, 1'b0);
      idle(10);
      chk("idle_u0", 16'({dp0, dm0, ns0, ed0, ov0}), 16'h0010);

      sync_bits = 8'b0000_0001;
      dpv = '0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, sync_bits[7-i]);
         dpv = {dpv[6:0], dp0};
      end
      chk("sync_dp", 16'(dpv), 16'(8'b0101_0100));
      eopv = '0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         eopv = {eopv[5:0], dp0, dm0, ed0};
      end
      chk("sync_eop", 16'(eopv), 16'(9'b000_000_101));
      idle(6);

      step(1'b0, 1'b1, 1'b0);
      holdv = '0;
      ns_all = ns0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 1'b1);
         holdv = {holdv[4:0], dp0};
         ns_all = ns_all & ns0;
      end
      step(1'b0, 1'b1, 1'b0);
      ns_all = ns_all & ns0;
      chk("stuff_hold", 16'(holdv), 16'h0000);
      chk("stuff_toggle", 16'({dp0, ns_all}), 16'(2'b11));
      idle(8);

      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      chk("rst_mid_u0", 16'({dp0, dm0, ns0, ed0}), 16'(4'b1000));
      chk("rst_mid_u1", 16'({dp1, dm1, ns1, ed1}), 16'(4'b1000));
      idle(8);

      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      ovcnt = 0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0);
         ovcnt += int'(ov0);
      end
      chk("ovr_count", 16'(ovcnt), 16'd3);
      step(1'b0, 1'b1, 1'b0);
      chk("ovr_restart", 16'({dp0, ns0, ov0}), 16'(3'b010));
      idle(10);

      step(1'b0, 1'b1, 1'b1);
      linev = {10'b0, dp1, dm1};
      donev = {5'b0, ed1};
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0);
         linev = {linev[9:0], dp1, dm1};
         donev = {donev[4:0], ed1};
      end
      chk("p32_lines", 16'(linev), 16'(12'b10_00_00_00_10_10));
      chk("p32_done", 16'(donev), 16'(6'b000001));
      step(1'b0, 1'b0, 1'b0);
      chk("p32_idle", 16'(ns1), 16'(1'b0));
      idle(4);

      bs_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) bs_r = !bs_r;
         step($urandom_range(0, 499) == 0, bs_r, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
